// File: rtl/fifo_put_arbiter.sv
// fifo_put_arbiter
// Shares one FIFO put port among N_REQ requesters. An owner is chosen by a
// round-robin scan that starts at a rotating pointer. The owner keeps the
// port for up to MAX_BURST accepted words, or until it drops its request.
// Backpressure from the FIFO (full_in) only pauses the burst. It never
// forces a release.
// While reset is high, every outward handshake is forced quiet. This means
// the FIFO never sees a put that word_count would then not count.

module fifo_put_arbiter #(
  parameter int N_BITS    = 32,
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk_put,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*N_BITS-1:0] data_in,
  input  logic                    full_in,
  output logic                    req_put,
  output logic [N_BITS-1:0]       data_put,
  output logic [N_REQ-1:0]        ack,
  output logic [N_REQ-1:0]        grant,
  output logic                    stall,
  output logic [15:0]             word_count
);

  localparam int             IW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [3:0]     LAST_BEAT = 4'(MAX_BURST - 1);
  localparam logic [IW-1:0]  LAST_IDX  = IW'(N_REQ - 1);
  localparam logic [IW:0]    N_REQ_EXT = (IW+1)'(N_REQ);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t        state;
  logic [IW-1:0] owner;
  logic [IW-1:0] ptr;
  logic [3:0]    cnt;

  logic          owned;
  logic          owner_req;
  logic          transfer;
  logic [IW-1:0] owner_next;
  logic [IW-1:0] pick;
  logic          pick_valid;

  assign owned      = (state == OWN) & ~reset;
  assign owner_req  = req[owner];
  assign transfer   = owned & owner_req & ~full_in;
  assign owner_next = (owner == LAST_IDX) ? '0 : owner + 1'b1;

  // Drive the FIFO-side and requester-side handshakes from the current owner
  always_comb begin
    req_put  = transfer;
    stall    = owned & owner_req & full_in;
    grant    = '0;
    ack      = '0;
    data_put = '0;
    if (owned) begin
      grant[owner] = 1'b1;
      data_put     = data_in[int'(owner)*N_BITS +: N_BITS];
    end
    if (transfer) begin
      ack[owner] = 1'b1;
    end
  end

  // Round-robin scan: the first pending request found at ptr, ptr+1, ... (mod N_REQ)
  always_comb begin
    logic [IW:0] sum;
    pick       = '0;
    pick_valid = 1'b0;
    sum        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= N_REQ_EXT) begin
        sum = sum - N_REQ_EXT;
      end
      if (!pick_valid && req[sum[IW-1:0]]) begin
        pick_valid = 1'b1;
        pick       = sum[IW-1:0];
      end
    end
  end

  // Ownership FSM, burst counter, rotate pointer and accepted-word counter
  always_ff @(posedge clk_put) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      ptr        <= '0;
      cnt        <= '0;
      word_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state <= OWN;
            owner <= pick;
            cnt   <= '0;
          end
        end
        OWN: begin
          if (transfer) begin
            word_count <= word_count + 16'd1;
            if (cnt == LAST_BEAT) begin
              state <= IDLE;
              ptr   <= owner_next;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end else if (!owner_req) begin
            state <= IDLE;
            ptr   <= owner_next;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_put_arbiter.sv
// tb_fifo_put_arbiter
// This is a directed bench for the FIFO put arbiter.
// The main instance uses the default parameters: 4 requesters with bursts of 4.
// A second, small instance has 2 requesters and bursts of 15. It is used to run
// the 16-bit word counter all the way through its wrap.

module tb_fifo_put_arbiter;

  localparam logic [127:0] DATA_WORDS = {32'h4444_DDDD, 32'h3333_CCCC,
                                         32'h2222_BBBB, 32'h1111_AAAA};

  logic         clk_put;
  logic         reset;
  logic [3:0]   req;
  logic [127:0] data_in;
  logic         full_in;
  logic         req_put;
  logic [31:0]  data_put;
  logic [3:0]   ack;
  logic [3:0]   grant;
  logic         stall;
  logic [15:0]  word_count;

  logic         reset2;
  logic [1:0]   req2;
  logic [15:0]  data_in2;
  logic         full2;
  logic         req_put2;
  logic [7:0]   data_put2;
  logic [1:0]   ack2;
  logic [1:0]   grant2;
  logic         stall2;
  logic [15:0]  word_count2;

  int vectors;
  int miscompares;

  fifo_put_arbiter #(.N_BITS(32), .N_REQ(4), .MAX_BURST(4)) dut (
    .clk_put    (clk_put),
    .reset      (reset),
    .req        (req),
    .data_in    (data_in),
    .full_in    (full_in),
    .req_put    (req_put),
    .data_put   (data_put),
    .ack        (ack),
    .grant      (grant),
    .stall      (stall),
    .word_count (word_count)
  );

  fifo_put_arbiter #(.N_BITS(8), .N_REQ(2), .MAX_BURST(15)) dut_wrap (
    .clk_put    (clk_put),
    .reset      (reset2),
    .req        (req2),
    .data_in    (data_in2),
    .full_in    (full2),
    .req_put    (req_put2),
    .data_put   (data_put2),
    .ack        (ack2),
    .grant      (grant2),
    .stall      (stall2),
    .word_count (word_count2)
  );

  // Free-running put clock with a 10 ns period
  initial clk_put = 1'b0;
  always #5 clk_put = ~clk_put;

  // Word that the main instance should present for a given one-hot grant
  function automatic logic [31:0] exp_data(input logic [3:0] g);
    case (g)
      4'b0001: return 32'h1111_AAAA;
      4'b0010: return 32'h2222_BBBB;
      4'b0100: return 32'h3333_CCCC;
      4'b1000: return 32'h4444_DDDD;
      default: return 32'h0000_0000;
    endcase
  endfunction

  task automatic applyStimulus(input logic [3:0] r, input logic f, input logic rst);
    req     = r;
    full_in = f;
    reset   = rst;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] g, input logic [3:0] a,
                             input logic s, input logic [15:0] wc);
    vectors++;
    assert (grant === g) else begin
      miscompares++;
      $error("[TB] FAIL %s grant: got %b want %b", tag, grant, g);
    end
    assert (ack === a) else begin
      miscompares++;
      $error("[TB] FAIL %s ack: got %b want %b", tag, ack, a);
    end
    assert (req_put === (|a)) else begin
      miscompares++;
      $error("[TB] FAIL %s req_put: got %b want %b", tag, req_put, |a);
    end
    assert (stall === s) else begin
      miscompares++;
      $error("[TB] FAIL %s stall: got %b want %b", tag, stall, s);
    end
    assert (word_count === wc) else begin
      miscompares++;
      $error("[TB] FAIL %s word_count: got %0d want %0d", tag, word_count, wc);
    end
    assert (data_put === exp_data(g)) else begin
      miscompares++;
      $error("[TB] FAIL %s data_put: got %h want %h", tag, data_put, exp_data(g));
    end
  endtask

  // One cycle: drive after the edge, check on the falling edge, then advance
  task automatic step(input string tag, input logic [3:0] r, input logic f, input logic rst,
                      input logic [3:0] g, input logic [3:0] a, input logic s,
                      input logic [15:0] wc);
    applyStimulus(r, f, rst);
    @(negedge clk_put);
    checkOutput(tag, g, a, s, wc);
    @(posedge clk_put);
    #1;
  endtask

  task automatic check2(input string tag, input logic [1:0] a, input logic [1:0] g,
                        input logic [15:0] wc);
    @(negedge clk_put);
    vectors++;
    assert (ack2 === a) else begin
      miscompares++;
      $error("[TB] FAIL %s ack: got %b want %b", tag, ack2, a);
    end
    assert (grant2 === g) else begin
      miscompares++;
      $error("[TB] FAIL %s grant: got %b want %b", tag, grant2, g);
    end
    assert (word_count2 === wc) else begin
      miscompares++;
      $error("[TB] FAIL %s word_count: got %h want %h", tag, word_count2, wc);
    end
    assert (data_put2 === ((g == 2'b01) ? 8'hA0 : 8'h00)) else begin
      miscompares++;
      $error("[TB] FAIL %s data_put: got %h", tag, data_put2);
    end
    assert (stall2 === 1'b0 && req_put2 === (|a)) else begin
      miscompares++;
      $error("[TB] FAIL %s stall/req_put: got %b/%b want 0/%b", tag, stall2, req_put2, |a);
    end
    @(posedge clk_put);
    #1;
  endtask

  task automatic skip(input int n);
    repeat (n) @(posedge clk_put);
    #1;
  endtask

  // Directed sequence
  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    req         = '0;
    full_in     = 1'b0;
    data_in     = DATA_WORDS;
    reset2      = 1'b1;
    req2        = '0;
    full2       = 1'b0;
    data_in2    = 16'hB1A0;
    @(posedge clk_put);
    #1;

    // Reset holds every output quiet, even with requests pending
    step("rst",     4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 16'd0);
    step("rst_req", 4'b1111, 0, 1, 4'b0000, 4'b0000, 0, 16'd0);

    // Single requester: a burst of 4, one gap cycle, a burst of 4
    step("s_idle", 4'b0001, 0, 0, 4'b0000, 4'b0000, 0, 16'd0);
    for (int i = 0; i < 4; i++)
      step("s_burst0", 4'b0001, 0, 0, 4'b0001, 4'b0001, 0, 16'(i));
    step("s_gap", 4'b0001, 0, 0, 4'b0000, 4'b0000, 0, 16'd4);
    for (int i = 0; i < 4; i++)
      step("s_burst1", 4'b0001, 0, 0, 4'b0001, 4'b0001, 0, 16'(4 + i));
    step("s_done", 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 16'd8);

    // Round robin across all four requesters, then wrap back to requester 0
    step("rr_rst", 4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 16'd8);
    for (int o = 0; o < 4; o++) begin
      step("rr_gap", 4'b1111, 0, 0, 4'b0000, 4'b0000, 0, 16'(4 * o));
      for (int b = 0; b < 4; b++)
        step("rr_own", 4'b1111, 0, 0, 4'(1 << o), 4'(1 << o), 0, 16'(4 * o + b));
    end
    step("rr_wrap_gap", 4'b1111, 0, 0, 4'b0000, 4'b0000, 0, 16'd16);
    step("rr_wrap",     4'b1111, 0, 0, 4'b0001, 4'b0001, 0, 16'd16);

    // Backpressure with owner 0 at cnt=1: hold for 5 cycles, then the three remaining words
    repeat (5)
      step("bp_stall", 4'b1111, 1, 0, 4'b0001, 4'b0000, 1, 16'd17);
    for (int b = 0; b < 3; b++)
      step("bp_resume", 4'b1111, 0, 0, 4'b0001, 4'b0001, 0, 16'(17 + b));

    // Early drop by owner 2 moves ptr to 3; the scan then wraps around to requester 0
    step("ed_gap",  4'b0100, 0, 0, 4'b0000, 4'b0000, 0, 16'd20);
    step("ed_own2", 4'b0100, 0, 0, 4'b0100, 4'b0100, 0, 16'd20);
    step("ed_drop", 4'b0000, 0, 0, 4'b0100, 4'b0000, 0, 16'd21);
    step("ed_idle", 4'b0101, 0, 0, 4'b0000, 4'b0000, 0, 16'd21);
    step("ed_wrap", 4'b0101, 0, 0, 4'b0001, 4'b0001, 0, 16'd21);

    // Reset in the middle of a burst: the would-be transfer is dropped and ptr returns to 0
    step("mr_beat",    4'b0101, 0, 0, 4'b0001, 4'b0001, 0, 16'd22);
    step("mr_reset",   4'b0101, 0, 1, 4'b0000, 4'b0000, 0, 16'd23);
    step("mr_after",   4'b1100, 0, 0, 4'b0000, 4'b0000, 0, 16'd0);
    step("mr_regrant", 4'b1100, 0, 0, 4'b0100, 4'b0100, 0, 16'd0);
    step("mr_end",     4'b0000, 0, 0, 4'b0100, 4'b0000, 0, 16'd1);

    // Counter wrap: each 16-cycle period is 1 idle cycle followed by 15 transfers.
    // Transfer t lands in cycle 16*((t-1)/15) + (t-1)%15 + 2.
    reset2 = 1'b0;
    req2   = 2'b01;
    check2("w_idle",  2'b00, 2'b00, 16'd0);
    check2("w_first", 2'b01, 2'b01, 16'd0);
    skip(14);
    check2("w_gap",   2'b00, 2'b00, 16'd15);
    skip(69888);
    check2("w_ffff",  2'b01, 2'b01, 16'hFFFF);
    check2("w_zero",  2'b01, 2'b01, 16'h0000);
    check2("w_one",   2'b01, 2'b01, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
